// File: rtl/mux_scan_serializer_pkg.sv
// Shared constants, FSM encoding and select-origin helper for the mux scan serializer.
package mux_scan_serializer_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StLast = 2'd2
  } state_e;

  // Select index the scan starts from: 0 for LSB-first, width-1 for MSB-first.
  function automatic int unsigned first_index(input bit msb_first,
                                              input int unsigned width = WIDTH);
    return msb_first ? width - 1 : 0;
  endfunction

endpackage

// File: rtl/mux_scan_serializer_scan_counter.sv
// Select/bit-counter pair: reloads to the first index on load, steps while enabled.
module mux_scan_serializer_scan_counter
  import mux_scan_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SEL_W     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [SEL_W-1:0] s,
  output logic [SEL_W:0]   cnt
);

  localparam logic [SEL_W-1:0] FIRST = SEL_W'(first_index(MSB_FIRST, WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= FIRST;
      cnt <= '0;
    end else if (load) begin
      s   <= FIRST;
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      s   <= MSB_FIRST ? s - 1'b1 : s + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Drives a latched word into an external 16:1 mux, scans its select and serializes the
// mux output, reassembling the stream into rx_word for loopback checking.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SEL_W     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             hold,
  output logic [SEL_W-1:0] s,
  output logic [WIDTH-1:0] in,
  input  logic             out,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_word
);

  localparam int unsigned CNT_W = SEL_W + 1;
  // Count value on the edge that samples bit WIDTH-2; the final bit is taken in StLast.
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(WIDTH - 2);

  state_e           state;
  logic [SEL_W:0]   cnt;
  logic             load;
  logic             step;

  assign load = (state == StIdle) && start;
  assign step = (state == StScan) && !hold;

  mux_scan_serializer_scan_counter #(
    .WIDTH     (WIDTH),
    .SEL_W     (SEL_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_scan_counter (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .s    (s),
    .cnt  (cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      in           <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rx_word      <= '0;
    end else begin
      serial_valid <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            in      <= data_in;
            rx_word <= '0;
            busy    <= 1'b1;
            state   <= StScan;
          end
        end
        StScan: begin
          if (!hold) begin
            serial_out   <= out;
            serial_valid <= 1'b1;
            rx_word[s]   <= out;
            if (cnt == PENULT) state <= StLast;
          end
        end
        StLast: begin
          serial_out   <= out;
          serial_valid <= 1'b1;
          rx_word[s]   <= out;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer: LSB- and MSB-first instances, each feeding a
// behavioural 16:1 mux, checked with immediate assertions against hand-derived values.
module tb_mux_scan_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        use1 = 1'b0;
  logic [15:0] data_in = '0;

  logic        start0, start1;
  logic [3:0]  s0, s1;
  logic [15:0] in0, in1, rx0, rx1;
  logic        out0, out1, so0, so1, sv0, sv1, busy0, busy1, done0, done1;

  logic [3:0]  o_s;
  logic [15:0] o_in, o_rx;
  logic        o_so, o_sv, o_busy, o_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign start0 = start && !use1;
  assign start1 = start && use1;

  // Behavioural stand-ins for the downstream mux16_1.
  assign out0 = in0[s0];
  assign out1 = in1[s1];

  assign o_s    = use1 ? s1    : s0;
  assign o_in   = use1 ? in1   : in0;
  assign o_rx   = use1 ? rx1   : rx0;
  assign o_so   = use1 ? so1   : so0;
  assign o_sv   = use1 ? sv1   : sv0;
  assign o_busy = use1 ? busy1 : busy0;
  assign o_done = use1 ? done1 : done0;

  mux_scan_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) dut0 (
    .clk (clk), .rst (rst), .start (start0), .data_in (data_in), .hold (hold),
    .s (s0), .in (in0), .out (out0), .serial_out (so0), .serial_valid (sv0),
    .busy (busy0), .done (done0), .rx_word (rx0)
  );

  mux_scan_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) dut1 (
    .clk (clk), .rst (rst), .start (start1), .data_in (data_in), .hold (hold),
    .s (s1), .in (in1), .out (out1), .serial_out (so1), .serial_valid (sv1),
    .busy (busy1), .done (done1), .rx_word (rx1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s0"}, 16'(s0), 16'd0);
    chk({tag, "_s1"}, 16'(s1), 16'd15);
    chk({tag, "_in"}, in0 | in1, 16'h0000);
    chk({tag, "_rx"}, rx0 | rx1, 16'h0000);
    chk({tag, "_flags"}, {12'd0, so0 | so1, sv0 | sv1, busy0 | busy1, done0 | done1}, 16'h0);
  endtask

  // Called at the sample point right after the accept edge.
  task automatic chk_accept(input string tag, input logic [15:0] word, input bit msb);
    chk({tag, "_busy"}, 16'(o_busy), 16'd1);
    chk({tag, "_valid"}, 16'(o_sv), 16'd0);
    chk({tag, "_in"}, o_in, word);
    chk({tag, "_s"}, 16'(o_s), msb ? 16'd15 : 16'd0);
  endtask

  // Walk the 16 bits of an accepted word; optional hold burst before bit hold_at and an
  // attempted re-start with 16'h1234 before bit poke_at.
  task automatic do_scan(input string tag, input logic [15:0] word, input bit msb,
                         input int hold_at, input int hold_len, input int poke_at);
    int idx;
    for (int k = 0; k < 16; k++) begin
      idx = msb ? 15 - k : k;
      if (k == hold_at) begin
        hold = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
          tick();
          chk($sformatf("%s_hold%0d_valid", tag, h), 16'(o_sv), 16'd0);
          chk($sformatf("%s_hold%0d_s", tag, h), 16'(o_s), 16'(idx));
        end
        hold = 1'b0;
      end
      if (k == poke_at) begin
        start   = 1'b1;
        data_in = 16'h1234;
      end
      tick();
      if (k == poke_at) start = 1'b0;
      chk($sformatf("%s_b%0d_valid", tag, k), 16'(o_sv), 16'd1);
      chk($sformatf("%s_b%0d_bit", tag, k), 16'(o_so), 16'(word[idx]));
      chk($sformatf("%s_b%0d_done", tag, k), 16'(o_done), 16'(k == 15));
      chk($sformatf("%s_b%0d_busy", tag, k), 16'(o_busy), 16'(k != 15));
      chk($sformatf("%s_b%0d_s", tag, k), 16'(o_s),
          k == 15 ? 16'(idx) : (msb ? 16'(idx - 1) : 16'(idx + 1)));
    end
    chk({tag, "_rx"}, o_rx, word);
    chk({tag, "_in_final"}, o_in, word);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_reset("reset");
    tick();
    rst = 1'b0;
    tick();
    chk_reset("idle");

    // Basic LSB-first scan
    data_in = 16'hAAAA;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk_accept("basic_acc", 16'hAAAA, 1'b0);
    do_scan("basic", 16'hAAAA, 1'b0, -1, 0, -1);
    tick();
    chk("basic_after_valid", 16'(o_sv), 16'd0);
    chk("basic_after_done", 16'(o_done), 16'd0);
    chk("basic_after_s", 16'(o_s), 16'd15);
    chk("basic_after_rx", o_rx, 16'hAAAA);

    // MSB-first scan on the second instance; hold in IDLE must not matter
    use1    = 1'b1;
    hold    = 1'b1;
    data_in = 16'h8001;
    start   = 1'b1;
    tick();
    start = 1'b0;
    hold  = 1'b0;
    chk_accept("rev_acc", 16'h8001, 1'b1);
    do_scan("rev", 16'h8001, 1'b1, -1, 0, -1);
    tick();
    chk("rev_after_s", 16'(o_s), 16'd0);
    use1 = 1'b0;

    // Hold for 3 cycles before bit 5
    data_in = 16'hF0F0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk_accept("hold_acc", 16'hF0F0, 1'b0);
    do_scan("hold", 16'hF0F0, 1'b0, 5, 3, -1);
    tick();

    // Start while busy is ignored
    data_in = 16'h00FF;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk_accept("ign_acc", 16'h00FF, 1'b0);
    do_scan("ign", 16'h00FF, 1'b0, -1, 0, 4);
    tick();

    // Back-to-back with start held high
    data_in = 16'h1357;
    start   = 1'b1;
    tick();
    data_in = 16'h2468;
    chk_accept("b2b1_acc", 16'h1357, 1'b0);
    do_scan("b2b1", 16'h1357, 1'b0, -1, 0, -1);
    tick();
    chk("b2b_gap_valid", 16'(o_sv), 16'd0);
    chk("b2b_gap_done", 16'(o_done), 16'd0);
    chk("b2b_gap_rx", o_rx, 16'h0000);
    chk_accept("b2b2_acc", 16'h2468, 1'b0);
    start = 1'b0;
    do_scan("b2b2", 16'h2468, 1'b0, -1, 0, -1);
    tick();

    // Reset during bit 7
    data_in = 16'hC3A5;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("rst_pre_bit7", 16'(o_so), 16'(data_in[7]));
    chk("rst_pre_busy", 16'(o_busy), 16'd1);
    #2 rst = 1'b1;
    #1 chk_reset("rst_async");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_hold%0d_done", k), 16'(o_done), 16'd0);
    end
    #2 rst = 1'b0;
    tick();
    chk_reset("rst_release");
    data_in = 16'h5A5A;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk_accept("post_acc", 16'h5A5A, 1'b0);
    do_scan("post", 16'h5A5A, 1'b0, -1, 0, -1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
